dt_estimator_mc: RTL

Multi-channel, parametrised successor to the single-channel temperature-derivative estimator. It accepts time-multiplexed temperature samples tagged with a channel index. For each channel it computes a clamped EMA of the scaled first difference: dT = clamp((1-a)·dT_prev + a·(ΔT>>k), ±d_max). Per-channel state lives in internal registers. The block sits between the sensor sample mux and the thermal controller, with valid/ready on both sides.

---
 rtl/dt_estimator_mc.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/dt_estimator_mc.sv
// dt_estimator_mc: per-channel clamped EMA of the scaled temperature slope.
// Optional sticky clamp status is built when DT_EST_SAT_STATUS_EN is defined.
module dt_estimator_mc #(
  parameter int N_CH    = 4,
  parameter int T_W     = 8,
  parameter int FRAC_W  = 7,
  parameter int ALPHA_W = 8,
  parameter int K_MAX   = 7,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [T_W-1:0]     in_T,
  input  logic [ALPHA_W-1:0] alpha,
  input  logic [3:0]         k_dt,
  input  logic [T_W-1:0]     d_max,
  input  logic               init,
  input  logic [N_CH-1:0]    init_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [T_W-1:0]     out_dT,
  output logic               out_primed,
  output logic [N_CH-1:0]    sat_flags,
  input  logic               sat_clr
);

  localparam int D_W   = T_W + FRAC_W + 1;
  localparam int SUM_W = D_W + ALPHA_W + 2;

  logic signed [T_W-1:0] t_prev [N_CH];
  logic signed [D_W-1:0] d_prev [N_CH];
  logic [N_CH-1:0]       primed;

  logic                  rdy_q;
  logic                  pipe_en;
  logic                  in_rng;

  logic                  s1_valid;
  logic                  s1_kill;
  logic [CH_W-1:0]       s1_ch;
  logic signed [T_W-1:0] s1_t;
  logic signed [D_W-1:0] s1_scaled;
  logic signed [D_W-1:0] s1_dprev;
  logic [ALPHA_W-1:0]    s1_alpha;
  logic [T_W-1:0]        s1_dmax;
  logic                  s1_primed;

  logic                  fwd;
  logic signed [T_W-1:0] t_base;
  logic signed [D_W-1:0] d_base;
  logic                  new_primed;
  logic signed [T_W:0]   delta;
  logic signed [D_W-1:0] sh_in;
  logic signed [D_W-1:0] scaled;
  logic [3:0]            k_eff;

  logic [ALPHA_W:0]        inv_a;
  logic signed [SUM_W-1:0] dp_x;
  logic signed [SUM_W-1:0] sc_x;
  logic signed [SUM_W-1:0] wa;
  logic signed [SUM_W-1:0] wb;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] avg;
  logic signed [SUM_W-1:0] lim;
  logic signed [SUM_W-1:0] clamped;
  logic                    sat_hit;
  logic signed [D_W-1:0]   q;
  logic signed [D_W-1:0]   bias;
  logic signed [D_W-1:0]   rnd;
  logic signed [D_W-1:0]   wb_d;
  logic [T_W-1:0]          dt_res;
  logic                    wb_en;

  assign in_ready = rdy_q & ~(out_valid & ~out_ready);
  assign pipe_en  = in_ready;
  assign in_rng   = 32'(in_ch) < N_CH;

  // ready comes up one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // S1: operand fetch with bypass of the writeback happening this edge
  always_comb begin
    fwd    = s1_valid & ~s1_kill & (s1_ch == in_ch);
    t_base = fwd ? s1_t : t_prev[in_ch];
    d_base = fwd ? wb_d : d_prev[in_ch];
    new_primed = (fwd | primed[in_ch]) & ~(init & init_mask[in_ch]);
    delta  = {in_T[T_W-1], in_T} - {t_base[T_W-1], t_base};
    k_eff  = (k_dt > 4'(K_MAX)) ? 4'(K_MAX) : k_dt;
    sh_in  = D_W'(delta);
    scaled = (sh_in <<< FRAC_W) >>> k_eff;
  end

  // S2: weighted blend, clamp and round-toward-zero output
  always_comb begin
    inv_a   = {1'b1, {ALPHA_W{1'b0}}} - {1'b0, s1_alpha};
    dp_x    = SUM_W'(s1_dprev);
    sc_x    = SUM_W'(s1_scaled);
    wa      = SUM_W'(inv_a);
    wb      = SUM_W'(s1_alpha);
    sum     = dp_x * wa + sc_x * wb;
    avg     = sum >>> ALPHA_W;
    lim     = SUM_W'({s1_dmax, {FRAC_W{1'b0}}});
    clamped = avg;
    sat_hit = 1'b0;
    if (avg > lim) begin
      clamped = lim;
      sat_hit = s1_primed;
    end else if (avg < -lim) begin
      clamped = -lim;
      sat_hit = s1_primed;
    end
    q      = D_W'(clamped);
    bias   = q[D_W-1] ? D_W'((2 ** FRAC_W) - 1) : D_W'(0);
    rnd    = q + bias;
    dt_res = T_W'(rnd >>> FRAC_W);
    wb_d   = s1_primed ? q : '0;
    wb_en  = pipe_en & s1_valid & ~s1_kill & ~(init & init_mask[s1_ch]);
  end

  // per-channel state: init clears, otherwise S2 writes back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= '0;
      for (int c = 0; c < N_CH; c++) begin
        t_prev[c] <= '0;
        d_prev[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (init & init_mask[c]) begin
          primed[c] <= 1'b0;
          t_prev[c] <= '0;
          d_prev[c] <= '0;
        end else if (wb_en && s1_ch == CH_W'(c)) begin
          primed[c] <= 1'b1;
          t_prev[c] <= s1_t;
          d_prev[c] <= wb_d;
        end
      end
    end
  end

  // S1 pipe register; a stalled entry hit by init loses its writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_kill   <= 1'b0;
      s1_ch     <= '0;
      s1_t      <= '0;
      s1_scaled <= '0;
      s1_dprev  <= '0;
      s1_alpha  <= '0;
      s1_dmax   <= '0;
      s1_primed <= 1'b0;
    end else if (pipe_en) begin
      s1_valid  <= in_valid & in_rng;
      s1_kill   <= 1'b0;
      s1_ch     <= in_ch;
      s1_t      <= in_T;
      s1_scaled <= scaled;
      s1_dprev  <= new_primed ? d_base : '0;
      s1_alpha  <= alpha;
      s1_dmax   <= d_max;
      s1_primed <= new_primed;
    end else if (init & s1_valid & init_mask[s1_ch]) begin
      s1_kill   <= 1'b1;
    end
  end

  // output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_dT     <= '0;
      out_primed <= 1'b0;
    end else if (pipe_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_ch     <= s1_ch;
        out_dT     <= s1_primed ? dt_res : '0;
        out_primed <= s1_primed;
      end
    end
  end

`ifdef DT_EST_SAT_STATUS_EN
  logic [N_CH-1:0] sat_q;
  logic [N_CH-1:0] sat_set;

  assign sat_set   = (pipe_en & s1_valid & sat_hit) ?
                     (N_CH'(1) << s1_ch) : '0;
  assign sat_flags = sat_q;

  // sticky clamp flags, a new set beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= '0;
    else        sat_q <= (sat_clr ? '0 : sat_q) | sat_set;
  end
`else
  logic unused_sat;
  assign unused_sat = sat_clr ^ sat_hit;
  assign sat_flags  = '0;
`endif

endmodule
